// File: rtl/mii_frame_gen.sv
`timescale 1ns/1ps
// Transmit frame generator for the 8-lane MII/BASE-R bus: START/preamble, payload, TERMINATE, IPG idles.
// Optional frame/byte statistics are built when MII_FRAME_GEN_STATS_EN is defined.
module mii_frame_gen #(
    parameter int          DATA_WIDTH = 64,
    parameter int          CTRL_WIDTH = 8,
    parameter logic [7:0]  IDLE_CODE  = 8'h07,
    parameter logic [7:0]  START_CODE = 8'hFB,
    parameter logic [7:0]  TERM_CODE  = 8'hFD,
    parameter logic [7:0]  ERR_CODE   = 8'hFE,
    parameter int          MIN_IPG    = 12
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [10:0]           i_payload_len,
    input  logic [7:0]            i_ipg_len,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic [CTRL_WIDTH-1:0] o_tx_ctrl,
    output logic                  o_busy,
    output logic                  o_underrun
`ifdef MII_FRAME_GEN_STATS_EN
    ,
    output logic [31:0]           o_frame_count,
    output logic [31:0]           o_byte_count
`endif
);

    // state    | meaning
    // S_IDLE   | idle words, waiting for i_start
    // S_PREAMBLE | START + preamble/SFD word
    // S_DATA   | full payload words, one per accepted i_data
    // S_TERM   | tail bytes + TERMINATE, rest idle
    // S_IPG    | idle words until the gap target is met
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_TERM,
        S_IPG
    } state_t;

    localparam logic [7:0]            MIN_IPG_B = 8'(MIN_IPG);
    localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {CTRL_WIDTH{IDLE_CODE}};
    localparam logic [DATA_WIDTH-1:0] ERR_WORD  = {CTRL_WIDTH{ERR_CODE}};
    localparam logic [DATA_WIDTH-1:0] PRE_WORD  = {8'hD5, {(CTRL_WIDTH-2){8'h55}}, START_CODE};

    state_t                state_q, state_d;
    logic [7:0]            words_q, words_d;
    logic [2:0]            rem_q, rem_d;
    logic [7:0]            target_q, target_d;
    logic [8:0]            idle_q, idle_d;
    logic [8:0]            idle_sum;
    logic                  ipg_last;
    logic                  load;
    logic                  starve;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic [CTRL_WIDTH-1:0] tx_ctrl_d;
    logic                  underrun_d;
    logic [DATA_WIDTH-1:0] term_data;
    logic [CTRL_WIDTH-1:0] term_ctrl;

    // Tail word: rem_q payload lanes, then TERMINATE, then idle fill.
    always_comb begin
        term_data = IDLE_WORD;
        term_ctrl = '1;
        for (int i = 0; i < CTRL_WIDTH; i++) begin
            if (i < int'(rem_q)) begin
                term_data[8*i +: 8] = i_data[8*i +: 8];
                term_ctrl[i]        = 1'b0;
            end else if (i == int'(rem_q)) begin
                term_data[8*i +: 8] = TERM_CODE;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        words_d      = words_q;
        rem_d        = rem_q;
        target_d     = target_q;
        idle_d       = idle_q;
        tx_data_d    = IDLE_WORD;
        tx_ctrl_d    = '1;
        underrun_d   = 1'b0;
        o_data_ready = 1'b0;
        o_busy       = 1'b1;
        load         = 1'b0;
        starve       = 1'b0;
        idle_sum     = idle_q + 9'd8;
        ipg_last     = (idle_sum >= {1'b0, target_q});

        case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    load    = 1'b1;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                tx_data_d = PRE_WORD;
                tx_ctrl_d = CTRL_WIDTH'(1);
                state_d   = (words_q != 8'd0) ? S_DATA : S_TERM;
            end
            S_DATA: begin
                if (i_data_valid) begin
                    o_data_ready = 1'b1;
                    tx_data_d    = i_data;
                    tx_ctrl_d    = '0;
                    words_d      = words_q - 8'd1;
                    if (words_q == 8'd1) begin
                        state_d = S_TERM;
                    end
                end else begin
                    starve = 1'b1;
                end
            end
            S_TERM: begin
                if (rem_q == 3'd0 || i_data_valid) begin
                    o_data_ready = (rem_q != 3'd0);
                    tx_data_d    = term_data;
                    tx_ctrl_d    = term_ctrl;
                    idle_d       = 9'(3'd7 - rem_q);
                    state_d      = S_IPG;
                end else begin
                    starve = 1'b1;
                end
            end
            S_IPG: begin
                idle_d = idle_sum;
                if (ipg_last) begin
                    o_busy = 1'b0;
                    if (i_start) begin
                        load    = 1'b1;
                        state_d = S_PREAMBLE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Starved payload aborts the frame: error word, gap counted from zero.
        if (starve) begin
            tx_data_d  = ERR_WORD;
            tx_ctrl_d  = '1;
            underrun_d = 1'b1;
            idle_d     = '0;
            state_d    = S_IPG;
        end

        if (load) begin
            words_d  = i_payload_len[10:3];
            rem_d    = i_payload_len[2:0];
            target_d = (i_ipg_len < MIN_IPG_B) ? MIN_IPG_B : i_ipg_len;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            words_q    <= '0;
            rem_q      <= '0;
            target_q   <= '0;
            idle_q     <= '0;
            o_tx_data  <= IDLE_WORD;
            o_tx_ctrl  <= '1;
            o_underrun <= 1'b0;
        end else begin
            state_q    <= state_d;
            words_q    <= words_d;
            rem_q      <= rem_d;
            target_q   <= target_d;
            idle_q     <= idle_d;
            o_tx_data  <= tx_data_d;
            o_tx_ctrl  <= tx_ctrl_d;
            o_underrun <= underrun_d;
        end
    end

`ifdef MII_FRAME_GEN_STATS_EN
    logic [10:0] len_q;

    // Only frames that reach a TERMINATE word are counted.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            len_q         <= '0;
            o_frame_count <= '0;
            o_byte_count  <= '0;
        end else begin
            if (load) begin
                len_q <= i_payload_len;
            end
            if (state_q == S_TERM && !starve) begin
                o_frame_count <= o_frame_count + 32'd1;
                o_byte_count  <= o_byte_count + 32'(len_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mii_frame_gen.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for mii_frame_gen: a frame-level model queues expected bus words,
// a monitor compares every bus word while a payload driver feeds the valid/ready stream.
module tb_mii_frame_gen;

    localparam logic [63:0] IDLE_W = 64'h0707070707070707;
    localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_start = 1'b0;
    logic [10:0] payload_len = '0;
    logic [7:0]  ipg_len = '0;
    logic [63:0] data = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [63:0] tx_data;
    logic [7:0]  tx_ctrl;
    logic        busy;
    logic        underrun;
`ifdef MII_FRAME_GEN_STATS_EN
    logic [31:0] frame_count;
    logic [31:0] byte_count;
`endif

    always #5 clk = ~clk;

    mii_frame_gen dut (
        .clk           (clk),
        .i_rst_n       (rst_n),
        .i_start       (i_start),
        .i_payload_len (payload_len),
        .i_ipg_len     (ipg_len),
        .i_data        (data),
        .i_data_valid  (data_valid),
        .o_data_ready  (data_ready),
        .o_tx_data     (tx_data),
        .o_tx_ctrl     (tx_ctrl),
        .o_busy        (busy),
        .o_underrun    (underrun)
`ifdef MII_FRAME_GEN_STATS_EN
        ,
        .o_frame_count (frame_count),
        .o_byte_count  (byte_count)
`endif
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic        u;
        bit          sync;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] pay_q[$];
    logic [63:0] fw[$];
    int          total = 0;
    int          bad = 0;
    int          consumed = 0;
    int          exp_consumed = 0;
    int          good_frames = 0;
    int          good_bytes = 0;
    bit          took = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic void push_exp(logic [63:0] d, logic [7:0] c, logic u, bit s);
        exp_t e;
        e.d = d; e.c = c; e.u = u; e.sync = s;
        exp_q.push_back(e);
    endfunction

    // Whole-frame reference: words derived from length, gap and how many payload words exist.
    function automatic void model_frame(int len, int ipg, int navail, bit s);
        int nfull, r, target, need, nd, gs, nipg;
        logic [63:0] d;
        logic [7:0]  c;
        nfull  = len / 8;
        r      = len % 8;
        target = (ipg < 12) ? 12 : ipg;
        need   = nfull + ((r > 0) ? 1 : 0);
        push_exp(PRE_W, 8'h01, 1'b0, s);
        nd = (navail < nfull) ? navail : nfull;
        for (int i = 0; i < nd; i++) push_exp(fw[i], 8'h00, 1'b0, 1'b0);
        if (navail < need) begin
            push_exp(ERR_W, 8'hFF, 1'b1, 1'b0);
            gs = 0;
            exp_consumed += navail;
        end else begin
            d = '0;
            c = '0;
            for (int l = 0; l < 8; l++) begin
                if (l < r) begin
                    d = d | (((fw[nfull] >> (8*l)) & 64'hFF) << (8*l));
                end else if (l == r) begin
                    d = d | (64'hFD << (8*l));
                    c = c | 8'(1 << l);
                end else begin
                    d = d | (64'h07 << (8*l));
                    c = c | 8'(1 << l);
                end
            end
            push_exp(d, c, 1'b0, 1'b0);
            gs = 7 - r;
            good_frames++;
            good_bytes += len;
            exp_consumed += need;
        end
        nipg = (target - gs + 7) / 8;
        for (int i = 0; i < nipg; i++) push_exp(IDLE_W, 8'hFF, 1'b0, 1'b0);
    endfunction

    // Payload source: offers the queue head whenever words are available.
    initial begin
        forever begin
            @(negedge clk);
            if (took && pay_q.size() > 0) begin
                void'(pay_q.pop_front());
                consumed++;
            end
            if (pay_q.size() > 0) begin
                data       = pay_q[0];
                data_valid = 1'b1;
            end else begin
                data       = {$urandom, $urandom};
                data_valid = 1'b0;
            end
            #1 took = data_ready && data_valid;
        end
    end

    // Monitor: every bus word is either an expected word or an idle between frames.
    initial begin
        int wait_cnt;
        exp_t e;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_data", tx_data, IDLE_W);
                    chk("unexpected_ctrl", 64'(tx_ctrl), 64'hFF);
                    chk("unexpected_underrun", 64'(underrun), 64'h0);
                end else if (exp_q[0].sync && tx_data == IDLE_W && tx_ctrl == 8'hFF && !underrun) begin
                    wait_cnt++;
                    if (wait_cnt > 400) begin
                        total++;
                        bad++;
                        $display("FAIL start_timeout: no START after %0d idle words, expected one", wait_cnt);
                        void'(exp_q.pop_front());
                        wait_cnt = 0;
                    end
                end else begin
                    wait_cnt = 0;
                    e = exp_q.pop_front();
                    chk("bus_data", tx_data, e.d);
                    chk("bus_ctrl", 64'(tx_ctrl), 64'(e.c));
                    chk("bus_underrun", 64'(underrun), 64'(e.u));
                end
            end
        end
    end

    task automatic wait_not_busy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #2;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL busy_timeout: busy still 1 after 3000 cycles, expected 0");
        end
    endtask

    task automatic gen_words(input int len);
        int need;
        need = len / 8 + ((len % 8 > 0) ? 1 : 0);
        fw.delete();
        for (int i = 0; i < need; i++) fw.push_back({$urandom, $urandom});
    endtask

    task automatic load_frame(input int len, input int ipg, input int navail, input bit s);
        gen_words(len);
        model_frame(len, ipg, navail, s);
        for (int i = 0; i < navail; i++) pay_q.push_back(fw[i]);
    endtask

    task automatic send_frame(input int len, input int ipg, input int navail);
        bit ok;
        bit s;
        wait_not_busy(ok);
        if (!ok) return;
        s = (exp_q.size() == 0);
        load_frame(len, ipg, navail, s);
        payload_len = 11'(len);
        ipg_len     = 8'(ipg);
        i_start     = 1'b1;
        @(negedge clk);
        #2 i_start = 1'b0;
    endtask

    // i_start held across two frames: the second must follow the first gap with no extra idle.
    task automatic send_b2b(input int len, input int ipg);
        bit ok;
        bit s;
        int need;
        need = len / 8 + ((len % 8 > 0) ? 1 : 0);
        wait_not_busy(ok);
        if (!ok) return;
        s = (exp_q.size() == 0);
        load_frame(len, ipg, need, s);
        load_frame(len, ipg, need, 1'b0);
        payload_len = 11'(len);
        ipg_len     = 8'(ipg);
        i_start     = 1'b1;
        wait_not_busy(ok);
        @(negedge clk);
        #2 i_start = 1'b0;
    endtask

    initial begin
        int len, ipg, need, navail;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_data", tx_data, IDLE_W);
        chk("reset_ctrl", 64'(tx_ctrl), 64'hFF);
        chk("reset_underrun", 64'(underrun), 64'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #2;
            chk("idle_data", tx_data, IDLE_W);
            chk("idle_ctrl", 64'(tx_ctrl), 64'hFF);
            chk("idle_busy", 64'(busy), 64'h0);
            chk("idle_ready", 64'(data_ready), 64'h0);
        end

        send_frame(64, 12, 8);
        send_frame(46, 20, 6);
        send_b2b(60, 5);
        send_frame(100, 12, 3);
        send_frame(64, 12, 8);
        repeat (3) @(negedge clk);
        #2;
        chk("busy_mid_frame", 64'(busy), 64'h1);
        payload_len = 11'd8;
        i_start     = 1'b1;
        @(negedge clk);
        #2 i_start = 1'b0;
        send_frame(64, 12, 8);
        send_frame(0, 0, 0);
        send_frame(7, 12, 1);
        send_frame(8, 255, 1);
        send_frame(15, 13, 1);

        for (int k = 0; k < 25; k++) begin
            len  = $urandom_range(0, 300);
            ipg  = $urandom_range(0, 40);
            need = len / 8 + ((len % 8 > 0) ? 1 : 0);
            navail = need;
            if (need > 0 && $urandom_range(0, 3) == 0) navail = $urandom_range(0, need - 1);
            if (k % 6 == 5) send_b2b(len, ipg);
            else            send_frame(len, ipg, navail);
        end

        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected words never appeared, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        #2;
        chk("words_consumed", 64'(consumed), 64'(exp_consumed));
`ifdef MII_FRAME_GEN_STATS_EN
        chk("frame_count", 64'(frame_count), 64'(good_frames));
        chk("byte_count", 64'(byte_count), 64'(good_bytes));
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
